if_prefetch_queue: RTL

Parametrised instruction prefetch unit that sits between the CPU's IF stage and the instruction bus master port. It fetches sequential instruction words ahead of consumption into a DEPTH-entry FIFO, and can issue back-to-back accesses within one bus grant (bursts). Each entry carries its word address. Branches and exceptions flush the queue through flush/new_pc.

---
 rtl/if_prefetch_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - sequential instruction prefetcher with burst bus fetch and flushable FIFO
module if_prefetch_queue #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                MAX_BURST = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    localparam int               CW        = $clog2(DEPTH + 1),
    localparam int               PW        = $clog2(DEPTH),
    localparam int               BW        = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              stall,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_insn,
    output logic [CW-1:0]     count,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    input  logic              bus_grnt_,
    output logic              bus_req_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACCESS} state_t;

    state_t            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              drop_q, drop_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d, count_nx;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [DATA_W-1:0] out_insn_q, out_insn_d;
    logic [ADDR_W-1:0] mem_pc_q [DEPTH];
    logic [DATA_W-1:0] mem_insn_q [DEPTH];
    logic              push, pop, head_is_new;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_as_d    = 1'b1;
        bus_addr_d  = bus_addr_q;
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;
        burst_cnt_d = burst_cnt_q;
        push        = 1'b0;
        pop         = out_valid_q & ~stall & ~flush;
        count_nx    = count_q;
        case (state_q)
            S_IDLE: begin
                if (!flush && int'(count_q) < DEPTH) begin
                    bus_req_d = 1'b0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    bus_req_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (!bus_grnt_) begin
                    bus_as_d    = 1'b0;
                    bus_addr_d  = fetch_pc_q;
                    burst_cnt_d = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!bus_rdy_) begin
                    push     = !drop_q && !flush;
                    count_nx = count_q + CW'(push) - CW'(pop);
                    if (!flush && !drop_q && int'(count_nx) < DEPTH &&
                        int'(burst_cnt_q) + 1 < MAX_BURST) begin
                        bus_as_d    = 1'b0;
                        bus_addr_d  = fetch_pc_q + ADDR_W'(1);
                        burst_cnt_d = burst_cnt_q + BW'(1);
                    end else begin
                        bus_req_d = 1'b1;
                        drop_d    = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else if (flush) begin
                    // Access is already on the bus; swallow its data when it lands.
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        if (flush) fetch_pc_d = new_pc;
    end

    always_comb begin
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        out_valid_d = count_d != '0;
        out_pc_d    = out_pc_q;
        out_insn_d  = out_insn_q;
        // Queue empties this cycle, so the word being pushed becomes the head.
        head_is_new = push && (count_q == CW'(pop));
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else if (out_valid_d) begin
            out_pc_d   = head_is_new ? fetch_pc_q : mem_pc_q[rd_ptr_d];
            out_insn_d = head_is_new ? bus_rd_data : mem_insn_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b1;
            bus_as_q    <= 1'b1;
            bus_addr_q  <= '0;
            fetch_pc_q  <= RESET_PC;
            drop_q      <= 1'b0;
            burst_cnt_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_insn_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_as_q    <= bus_as_d;
            bus_addr_q  <= bus_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
            burst_cnt_q <= burst_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_insn_q  <= out_insn_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_insn_q[wr_ptr_q] <= bus_rd_data;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_insn    = out_insn_q;
    assign count       = count_q;
    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = 1'b1;
    assign bus_wr_data = '0;
endmodule
